// File: rtl/thermal_pkg.sv
// Shared types and constants for the thermal covert-channel transmitter.
package thermal_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_GUARD
  } state_t;

  localparam int PREAMBLE_LEN = 4;
  localparam logic [PREAMBLE_LEN-1:0] PREAMBLE = 4'b1010;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/thermal_bit_timer.sv
// Loadable down-counter; tick_o flags the last cycle of a loaded interval.
module thermal_bit_timer #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter parks at zero once expired, so an idle timer keeps ticking harmlessly.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/thermal_tx_scheduler.sv
// Serialises preamble + payload as heater on/off slots, followed by a forced cool-down guard.
module thermal_tx_scheduler
  import thermal_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int BIT_CYCLES   = 1024,
  parameter int GUARD_CYCLES = 2048
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  input  logic              abort,
  output logic              heat_en,
  output logic              busy,
  output logic [3:0]        bit_index,
  output logic              frame_done
);

  localparam int CNT_W   = $clog2(max_int(BIT_CYCLES, GUARD_CYCLES));
  localparam int FRAME_W = PREAMBLE_LEN + DATA_W;
  localparam logic [CNT_W-1:0] BIT_LOAD   = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [3:0]       LAST_IDX   = 4'(FRAME_W - 1);
  localparam logic [3:0]       DATA_IDX   = 4'(PREAMBLE_LEN);

  state_t             state_q;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [3:0]         bit_idx_q, bit_idx_d;
  logic               heat_q, busy_q, ready_q, done_q, aborted_q;
  logic               last_bit;

  logic               tmr_load, tmr_tick;
  logic [CNT_W-1:0]   tmr_val, tmr_cnt;

  thermal_bit_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .cnt_o     (tmr_cnt),
    .tick_o    (tmr_tick)
  );

  // Timer reloads on accept, on every slot boundary, and when entering guard.
  always_comb begin
    frame_d   = frame_q << 1;
    bit_idx_d = bit_idx_q + 4'd1;
    last_bit  = (bit_idx_q == LAST_IDX);
    tmr_load  = 1'b0;
    tmr_val   = BIT_LOAD;
    case (state_q)
      S_IDLE: tmr_load = tx_valid;
      S_PREAMBLE, S_DATA: begin
        if (abort) begin
          tmr_load = 1'b1;
          tmr_val  = GUARD_LOAD;
        end else if (tmr_tick) begin
          tmr_load = 1'b1;
          tmr_val  = last_bit ? GUARD_LOAD : BIT_LOAD;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      frame_q   <= '0;
      bit_idx_q <= '0;
      heat_q    <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (tx_valid) begin
            state_q   <= S_PREAMBLE;
            frame_q   <= {PREAMBLE, tx_data};
            bit_idx_q <= '0;
            heat_q    <= PREAMBLE[PREAMBLE_LEN-1];
            busy_q    <= 1'b1;
            ready_q   <= 1'b0;
            aborted_q <= 1'b0;
          end
        end
        S_PREAMBLE, S_DATA: begin
          // Abort takes priority over a coincident final-slot completion.
          if (abort || (tmr_tick && last_bit)) begin
            state_q   <= S_GUARD;
            heat_q    <= 1'b0;
            bit_idx_q <= '0;
            aborted_q <= abort;
            done_q    <= !abort && (GUARD_CYCLES == 1);
          end else if (tmr_tick) begin
            frame_q   <= frame_d;
            bit_idx_q <= bit_idx_d;
            heat_q    <= frame_d[FRAME_W-1];
            if (bit_idx_d >= DATA_IDX) begin
              state_q <= S_DATA;
            end
          end
        end
        S_GUARD: begin
          if (tmr_tick) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            done_q <= !aborted_q && (tmr_cnt == CNT_W'(1));
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign heat_en    = heat_q;
  assign busy       = busy_q;
  assign tx_ready   = ready_q;
  assign frame_done = done_q;
  assign bit_index  = bit_idx_q;

endmodule

// File: tb/tb_thermal_tx_scheduler.sv
// Bench for thermal_tx_scheduler: table of frames with a per-cycle expected-output scoreboard.
module tb_thermal_tx_scheduler;

  localparam int DW    = 8;
  localparam int BC    = 4;
  localparam int GC    = 8;
  localparam int NSLOT = (4 + DW) * BC;

  typedef struct packed {
    logic       heat;
    logic       busy;
    logic       ready;
    logic       done;
    logic [3:0] idx;
  } obs_t;

  typedef struct {
    logic [7:0] data;
    int         abort_at;
    bit         abort_idle;
    bit         abort_guard;
  } vec_t;

  localparam logic [7:0] MASK_ALL    = 8'hFF;
  localparam logic [7:0] MASK_NO_RDY = 8'hDF;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          tx_valid = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          abort = 1'b0;
  logic          tx_ready, heat_en, busy, frame_done;
  logic [3:0]    bit_index;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[7];

  thermal_tx_scheduler #(
    .DATA_W      (DW),
    .BIT_CYCLES  (BC),
    .GUARD_CYCLES(GC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .abort     (abort),
    .heat_en   (heat_en),
    .busy      (busy),
    .bit_index (bit_index),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic h, input logic b, input logic r,
                              input logic d, input logic [3:0] i);
    obs_t o;
    o.heat = h; o.busy = b; o.ready = r; o.done = d; o.idx = i;
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(heat_en, busy, tx_ready, frame_done, bit_index);
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp,
                       input logic [7:0] mask);
    n_cmp++;
    if ((got & mask) !== (exp & mask)) begin
      n_bad++;
      $display("FAIL %s @%0t got heat=%b busy=%b rdy=%b done=%b idx=%0d required heat=%b busy=%b rdy=%b done=%b idx=%0d",
               name, $time, got.heat, got.busy, got.ready, got.done, got.idx,
               exp.heat, exp.busy, exp.ready, exp.done, exp.idx);
    end
  endtask

  // Expected outputs for cycles 1.. after the accept edge, ending with the first idle cycle.
  task automatic push_expected(input logic [7:0] d, input int a);
    logic [11:0] fb;
    int gs, ge, b;
    fb = {4'b1010, d};
    gs = (a < 0) ? NSLOT + 1 : a + 1;
    ge = gs + GC - 1;
    for (int k = 1; k <= ge + 1; k++) begin
      if (k < gs) begin
        b = (k - 1) / BC;
        exp_q.push_back(mk(fb[11-b], 1'b1, 1'b0, 1'b0, 4'(b)));
      end else if (k <= ge) begin
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, (a < 0) && (k == ge), 4'd0));
      end else begin
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd0));
      end
    end
  endtask

  task automatic run_frame(input logic [7:0] d, input int a, input bit abort_idle,
                           input bit abort_guard, input bit hold_ff, input bit already);
    int len, gs;
    if (!already) begin
      tx_valid = 1'b1;
      tx_data  = d;
      abort    = abort_idle;
      @(posedge clk); #1;
      abort = 1'b0;
    end
    if (hold_ff) begin
      tx_valid = 1'b1;
      tx_data  = 8'hFF;
    end else begin
      tx_valid = 1'b0;
    end
    push_expected(d, a);
    len = exp_q.size();
    gs  = (a < 0) ? NSLOT + 1 : a + 1;
    for (int k = 1; k <= len; k++) begin
      abort = (k == a) || (abort_guard && k >= gs && k < gs + GC);
      @(negedge clk);
      check($sformatf("frame_%02h_c%0d", d, k), sample(), exp_q.pop_front(), MASK_ALL);
      @(posedge clk); #1;
    end
    abort = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'hA5, -1, 1'b0, 1'b0};
    vecs[1] = '{8'h00, -1, 1'b0, 1'b0};
    vecs[2] = '{8'h5A, 26, 1'b0, 1'b0};
    vecs[3] = '{8'hC3, -1, 1'b1, 1'b1};
    vecs[4] = '{8'h3C,  6, 1'b0, 1'b0};
    vecs[5] = '{8'h81, 48, 1'b0, 1'b0};
    vecs[6] = '{8'hFF,  1, 1'b0, 1'b0};

    // Reset held: all outputs quiescent.
    #12;
    check("in_reset", sample(), mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0), MASK_NO_RDY);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("idle_%0d", i), sample(), mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd0), MASK_ALL);
      @(posedge clk); #1;
    end

    for (int v = 0; v < 7; v++) begin
      run_frame(vecs[v].data, vecs[v].abort_at, vecs[v].abort_idle, vecs[v].abort_guard,
                1'b0, 1'b0);
    end

    // tx_valid held with new data during a busy frame: second frame only after ready.
    run_frame(8'hA5, -1, 1'b0, 1'b0, 1'b1, 1'b0);
    run_frame(8'hFF, -1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-frame: heater drops immediately, no guard, no completion pulse.
    tx_valid = 1'b1;
    tx_data  = 8'h5A;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("pre_reset_c10", sample(), mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd2), MASK_ALL);
    #2 reset = 1'b0;
    #1;
    check("async_reset", sample(), mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0), MASK_NO_RDY);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("post_reset_%0d", i), sample(), mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd0), MASK_ALL);
      @(posedge clk); #1;
    end

    // Normal frame afterwards confirms clean recovery.
    run_frame(8'h96, -1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
